fifo_wr_arbiter: RTL
====================

# fifo_wr_arbiter

Write-side arbiter that shares the single write port of the async FIFO between `NUM_REQ` independent producers in the write clock domain. Each producer presents a valid/ready stream. The arbiter grants the FIFO write port round-robin, optionally holding a grant for a bounded burst, and never writes while the FIFO reports full. It sits between the producer blocks and the FIFO's write-side interface.

## Interface
- `DATA_WIDTH`, 8: width of one FIFO word.
- `NUM_REQ`, 4: number of requesters, ≥2.
- `MAX_BURST`, 4: max consecutive beats per grant, ≥1; used only with `FIFO_ARB_BURST_EN`.

- `i_clk`  in  1: write-domain clock, rising edge.
- `i_rst`  in  1: reset, asynchronous, active-high.
- `i_req_valid`  in  NUM_REQ: per-requester beat valid.
- `i_req_data`  in  NUM_REQ*DATA_WIDTH: requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- `o_req_ready`  out  NUM_REQ: per-requester beat accepted this cycle.
- `i_full`  in  1: FIFO full flag, write domain.
- `o_wr_en`  out  1: FIFO write enable.
- `o_wdata`  out  DATA_WIDTH: FIFO write data.
- `o_grant`  out  NUM_REQ: registered one-hot current grant; all zeros when idle.
- `o_grant_id`  out  $clog2(NUM_REQ): registered index of the current grant; 0 when idle.

## Operation
- Two states: IDLE (no grant) and LOCK (grant held by `gid`).
- Registered state: `state`, `gid`, `ptr` (last served, width $clog2(NUM_REQ)), `cnt` (beats in current grant, width $clog2(MAX_BURST+1)).
- Beat rule in LOCK: `o_req_ready[gid] = ~i_full`. `o_wr_en = i_req_valid[gid] & ~i_full`. `o_wdata` is the `gid` slice of `i_req_data`. All other ready bits are 0.
- In IDLE: `o_wr_en`, `o_wdata`, and all ready bits are 0.
- Arbitration fires on a cycle in IDLE, or on a release cycle in LOCK.
  - Scan starts at `ptr+1` modulo `NUM_REQ`; the first requester with valid high wins.
  - Winner registered into `gid`, `state` goes to LOCK, `cnt` cleared.
  - No requester valid: go to IDLE.
- Release in LOCK, either condition:
  - `i_req_valid[gid]` is low: no beat this cycle.
  - A beat is accepted and `cnt == MAX_BURST-1`.
  - On release, `ptr <= gid`.
- A release and the next grant happen in the same cycle, so there is no bubble between grants.
- Stall: LOCK with valid high and `i_full` high gives no beat, no `cnt` change, no release. The grant is held indefinitely while full.
- Requesters hold data stable while valid is high and ready is low. A requester drops valid only after a beat is accepted.
- Accepted beat with no release: `cnt <= cnt+1`.

## Timing
- Reset values: `state` = IDLE, `ptr` = NUM_REQ-1 (requester 0 has first priority), `gid` = 0, `cnt` = 0. All outputs are 0.
- While `i_rst` is high, `o_wr_en` and `o_req_ready` are forced to 0 combinationally.
- Grant latency: 1 cycle from valid rising in IDLE to `o_grant` asserting. The first beat is written in that same granted cycle if not full.
- `o_wr_en`/`o_wdata` are combinational from registered grant, `i_req_valid`, `i_req_data`, and `i_full`. There is no write latency inside the block.
- Throughput: one beat per cycle when not full, including across grant handovers.
- Reset asserted mid-burst: the current beat is dropped (ready and write enable are 0). After release, arbitration restarts from requester 0.
- Lone requester: it re-wins immediately at burst end, with no bubble.

## Configuration
- `FIFO_ARB_BURST_EN` defined: a grant holds for up to `MAX_BURST` beats as above.
- Not defined: release happens after every accepted beat (effective `MAX_BURST` = 1). `cnt` is not implemented. `MAX_BURST` is ignored. The result is strict per-beat round-robin.

## Test plan
- Reset with all inputs active → all outputs 0. After release with req0..3 valid, `o_grant_id` = 0 on the first cycle.
- Requester 1 alone sends 0xA0–0xA5 continuously, burst on, `MAX_BURST`=4 → 6 writes in 6 consecutive granted cycles, data in order, `o_grant` = 4'b0010 throughout.
- All 4 requesters continuously valid → burst on: `o_grant_id` sequence 0,0,0,0,1,1,1,1,2,… Burst off: 0,1,2,3,0,…. Exactly one `o_wr_en` per cycle.
- `i_full` held high 3 cycles after beat 2 of requester 2's burst → `o_wr_en`=0 for 3 cycles, `o_grant_id` stays 2. Beats 3–4 follow, then the grant moves to 3.
- Requester 0 drops valid after 2 beats while requester 3 is valid → next cycle `o_grant_id` = 3, no lost or duplicated word.
- `i_rst` pulsed mid-burst of requester 2 → `o_wr_en`/ready go to 0 immediately. After release, requester 0 is granted first and the FIFO contents match the scoreboard.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: producer valid/ready streams plus the shared FIFO write port
interface fifo_wr_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0] i_req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data;
    logic [NUM_REQ-1:0] o_req_ready;
    logic i_full;
    logic o_wr_en;
    logic [DATA_WIDTH-1:0] o_wdata;
    logic [NUM_REQ-1:0] o_grant;
    logic [$clog2(NUM_REQ)-1:0] o_grant_id;
    modport slave (
        input i_req_valid, i_req_data, i_full,
        output o_req_ready, o_wr_en, o_wdata, o_grant, o_grant_id
    );
    modport master (
        output i_req_valid, i_req_data, i_full,
        input o_req_ready, o_wr_en, o_wdata, o_grant, o_grant_id
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin sharing of the async FIFO write port among NUM_REQ producers
// FIFO_ARB_BURST_EN: hold each grant for up to MAX_BURST beats; otherwise one beat per grant
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ = 4,
    parameter int MAX_BURST = 4
) (
    input logic i_clk,
    input logic i_rst,
    fifo_wr_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);
    typedef enum logic {IDLE, LOCK} state_t;
    state_t state, state_nxt;
    logic [IW-1:0] gid, gid_nxt, ptr, ptr_nxt, base, win;
    logic found, lock, beat, last, rel, arb;
    logic [NUM_REQ-1:0] gid_oh;
`ifdef FIFO_ARB_BURST_EN
    localparam int CW = $clog2(MAX_BURST + 1);
    logic [CW-1:0] cnt, cnt_nxt;
    assign last = cnt == CW'(MAX_BURST - 1);
`else
    // every accepted beat ends the grant (MAX_BURST is always >= 1)
    assign last = MAX_BURST >= 1;
`endif
    assign lock = state == LOCK;
    assign gid_oh = lock ? NUM_REQ'(1) << gid : '0;
    assign beat = lock & bus.i_req_valid[gid] & ~bus.i_full;
    assign rel = lock & (~bus.i_req_valid[gid] | (beat & last));
    assign arb = ~lock | rel;
    // a releasing grant already counts as last served, so the handover needs no bubble
    assign base = rel ? gid : ptr;
    always_comb begin
        int idx;
        found = 1'b0;
        win = base;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(base) + i) % NUM_REQ;
            if (!found && bus.i_req_valid[idx]) begin
                found = 1'b1;
                win = IW'(idx);
            end
        end
    end
    always_comb begin
        state_nxt = state;
        gid_nxt = gid;
        ptr_nxt = rel ? gid : ptr;
        if (arb) begin
            state_nxt = found ? LOCK : IDLE;
            gid_nxt = found ? win : gid;
        end
    end
`ifdef FIFO_ARB_BURST_EN
    assign cnt_nxt = arb ? '0 : beat ? cnt + 1'b1 : cnt;
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) cnt <= '0;
        else cnt <= cnt_nxt;
`endif
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            state <= IDLE;
            gid <= '0;
            ptr <= IW'(NUM_REQ - 1);
        end else begin
            state <= state_nxt;
            gid <= gid_nxt;
            ptr <= ptr_nxt;
        end
    assign bus.o_grant = gid_oh;
    assign bus.o_grant_id = lock ? gid : '0;
    assign bus.o_req_ready = (bus.i_full | i_rst) ? '0 : gid_oh;
    assign bus.o_wr_en = beat & ~i_rst;
    assign bus.o_wdata = lock ? bus.i_req_data[gid*DATA_WIDTH +: DATA_WIDTH] : '0;
endmodule
